// File: rtl/obf_key_pkg.sv
// Shared encodings, FSM state type and key-length helper for the obfuscated-cell key loader.
// Purely declarative: no logic, no latency, no flow control.
package obf_key_pkg;

    // Per-cell {D_2i+1, D_2i} key encoding
    localparam logic [1:0] OBF_PASS = 2'b00;
    localparam logic [1:0] OBF_INV  = 2'b10;
    localparam logic [1:0] OBF_ONE  = 2'b01;
    localparam logic [1:0] OBF_ZERO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_CHK    = 2'd2,
        ST_COMMIT = 2'd3
    } obf_state_e;

    function automatic int key_len(input int n_cells);
        return 2 * n_cells;
    endfunction

endpackage

// File: rtl/obf_key_shift_reg.sv
// Indexed shadow register with saturating beat counter; a write lands in bit cnt on the next edge.
// No backpressure of its own: the caller gates load_i, and clr_i takes priority over load_i.
module obf_key_shift_reg #(
    parameter int KEY_LEN = 10,
    parameter int CW      = $clog2(KEY_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               load_i,
    input  logic               bit_i,
    output logic [KEY_LEN-1:0] shadow_o,
    output logic [CW-1:0]      cnt_o,
    output logic               full_o
);

    logic [KEY_LEN-1:0] shadow_q, shadow_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            shadow_d = '0;
            cnt_d    = '0;
        end else if (load_i && (cnt_q != CW'(KEY_LEN))) begin
            for (int i = 0; i < KEY_LEN; i++) begin
                if (cnt_q == CW'(i)) shadow_d[i] = bit_i;
            end
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign shadow_o = shadow_q;
    assign cnt_o    = cnt_q;
    assign full_o   = (cnt_q == CW'(KEY_LEN));

endmodule

// File: rtl/obf_key_loader.sv
// Serial-to-parallel camouflage key loader; key_out/load_done update one cycle after COMMIT is entered.
// key_ready is high only in SHIFT (and CHK when OBF_KEY_PARITY_EN adds the even-parity beat).
module obf_key_loader
    import obf_key_pkg::*;
#(
    parameter int N_CELLS        = 5,
    parameter bit LOCK_ON_COMMIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic                 key_bit,
    input  logic                 key_valid,
    output logic                 key_ready,
    output logic [2*N_CELLS-1:0] key_out,
    output logic                 busy,
    output logic                 load_done,
    output logic                 load_err,
    output logic                 key_locked
);

    localparam int KEY_LEN = key_len(N_CELLS);
    localparam int CW      = $clog2(KEY_LEN + 1);

    obf_state_e         state_q, state_d;
    logic [KEY_LEN-1:0] key_out_q, key_out_d;
    logic               locked_q, locked_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               sr_clr, sr_load, sr_full, beat_acc;
    logic [KEY_LEN-1:0] shadow;
    logic [CW-1:0]      cnt;

    obf_key_shift_reg #(
        .KEY_LEN (KEY_LEN),
        .CW      (CW)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (sr_clr),
        .load_i   (sr_load),
        .bit_i    (key_bit),
        .shadow_o (shadow),
        .cnt_o    (cnt),
        .full_o   (sr_full)
    );

    assign key_ready = (state_q == ST_SHIFT) || (state_q == ST_CHK);
    assign beat_acc  = key_valid && key_ready;

    always_comb begin
        state_d   = state_q;
        key_out_d = key_out_q;
        locked_d  = locked_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        sr_clr    = 1'b0;
        sr_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    if (locked_q) begin
                        err_d = 1'b1;
                    end else begin
                        sr_clr  = 1'b1;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                // A restart wins over a beat handshaked in the same cycle
                if (load_start) begin
                    sr_clr = 1'b1;
                end else if (beat_acc) begin
                    sr_load = 1'b1;
                    if (cnt == CW'(KEY_LEN - 1)) begin
`ifdef OBF_KEY_PARITY_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_COMMIT;
`endif
                    end
                end
            end
`ifdef OBF_KEY_PARITY_EN
            ST_CHK: begin
                if (load_start) begin
                    sr_clr  = 1'b1;
                    state_d = ST_SHIFT;
                end else if (beat_acc) begin
                    if (key_bit == ^shadow) begin
                        state_d = ST_COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
`endif
            ST_COMMIT: begin
                if (sr_full) begin
                    key_out_d = shadow;
                    done_d    = 1'b1;
                    if (LOCK_ON_COMMIT) locked_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            key_out_q <= '0;
            locked_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_out_q <= key_out_d;
            locked_q  <= locked_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign key_out    = key_out_q;
    assign busy       = (state_q != ST_IDLE);
    assign load_done  = done_q;
    assign load_err   = err_q;
    assign key_locked = locked_q;

endmodule

// File: tb/tb_obf_key_loader.sv
// Bench for obf_key_loader: one locking and one non-locking instance, expected keys queued per instance.
module tb_obf_key_loader;

    localparam int N  = 5;
    localparam int KL = 2 * N;
`ifdef OBF_KEY_PARITY_EN
    localparam int EXP_BEATS = KL + 1;
`else
    localparam int EXP_BEATS = KL;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    ls = '0;
    logic [1:0]    kb = '0;
    logic [1:0]    kv = '0;
    logic [KL-1:0] ko [2];
    logic [1:0]    rdy, bsy, dn, er, lk;

    int            checks = 0;
    int            errors = 0;
    int            acc_cnt [2] = '{0, 0};
    logic [KL-1:0] exp_q0 [$];
    logic [KL-1:0] exp_q1 [$];

    obf_key_loader #(.N_CELLS(N), .LOCK_ON_COMMIT(1'b1)) u_lk (
        .clk(clk), .rst_n(rst_n), .load_start(ls[0]), .key_bit(kb[0]), .key_valid(kv[0]),
        .key_ready(rdy[0]), .key_out(ko[0]), .busy(bsy[0]), .load_done(dn[0]),
        .load_err(er[0]), .key_locked(lk[0])
    );

    obf_key_loader #(.N_CELLS(N), .LOCK_ON_COMMIT(1'b0)) u_nl (
        .clk(clk), .rst_n(rst_n), .load_start(ls[1]), .key_bit(kb[1]), .key_valid(kv[1]),
        .key_ready(rdy[1]), .key_out(ko[1]), .busy(bsy[1]), .load_done(dn[1]),
        .load_err(er[1]), .key_locked(lk[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int s = 0; s < 2; s++)
            if (kv[s] && rdy[s]) acc_cnt[s] <= acc_cnt[s] + 1;
    end

    // Scoreboard: every load_done pulse must match the oldest queued key
    always @(negedge clk) begin
        if (dn[0]) begin
            if (exp_q0.size() == 0) chk("done0_unexpected", 1, 0);
            else                    chk("key_out0", {22'd0, ko[0]}, {22'd0, exp_q0.pop_front()});
        end
        if (dn[1]) begin
            if (exp_q1.size() == 0) chk("done1_unexpected", 1, 0);
            else                    chk("key_out1", {22'd0, ko[1]}, {22'd0, exp_q1.pop_front()});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives a junk beat alongside load_start; it must never be taken
    task automatic start(input int s);
        ls[s] = 1'b1;
        kv[s] = 1'b1;
        kb[s] = 1'b0;
        cyc();
        ls[s] = 1'b0;
        kv[s] = 1'b0;
    endtask

    task automatic beats(input int s, input logic [KL-1:0] v, input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++) begin
                    kv[s] = 1'b0;
                    kb[s] = 1'($urandom_range(1, 0));
                    cyc();
                end
            end
            kb[s] = v[i];
            kv[s] = 1'b1;
            cyc();
        end
        kv[s] = 1'b0;
    endtask

    task automatic load_key(input int s, input logic [KL-1:0] key, input bit par_ok, input bit rnd);
        int            a0;
        logic [KL-1:0] prev;
        prev = ko[s];
        if (par_ok) begin
            if (s == 0) exp_q0.push_back(key);
            else        exp_q1.push_back(key);
        end
        start(s);
        a0 = acc_cnt[s];
        beats(s, key, KL, rnd);
`ifdef OBF_KEY_PARITY_EN
        chk("rdy_in_chk", {31'd0, rdy[s]}, 1);
        kb[s] = (^key) ^ !par_ok;
        kv[s] = 1'b1;
        cyc();
        kv[s] = 1'b0;
        if (!par_ok) begin
            chk("err_parity", {31'd0, er[s]}, 1);
            chk("busy_after_parity_err", {31'd0, bsy[s]}, 0);
            chk("ko_after_parity_err", {22'd0, ko[s]}, {22'd0, prev});
            cyc();
            return;
        end
`endif
        chk("rdy_in_commit", {31'd0, rdy[s]}, 0);
        chk("busy_in_commit", {31'd0, bsy[s]}, 1);
        chk("done_early", {31'd0, dn[s]}, 0);
        chk("ko_hold_until_commit", {22'd0, ko[s]}, {22'd0, prev});
        cyc();
        chk("done_pulse", {31'd0, dn[s]}, 1);
        chk("accepted_beats", acc_cnt[s] - a0, EXP_BEATS);
        cyc();
        chk("done_one_cycle", {31'd0, dn[s]}, 0);
        chk("busy_idle", {31'd0, bsy[s]}, 0);
    endtask

    initial begin
        logic [KL-1:0] key;
        repeat (2) cyc();
        for (int s = 0; s < 2; s++) begin
            chk("rst_key_out", {22'd0, ko[s]}, 0);
            chk("rst_busy", {31'd0, bsy[s]}, 0);
            chk("rst_ready", {31'd0, rdy[s]}, 0);
            chk("rst_locked", {31'd0, lk[s]}, 0);
            chk("rst_done_err", {30'd0, dn[s], er[s]}, 0);
        end
        rst_n = 1'b1;
        cyc();

        // Locking instance: first commit, then every load is rejected
        key = 10'b11_01_10_00_00;
        load_key(0, key, 1'b1, 1'b0);
        chk("ko_first", {22'd0, ko[0]}, {22'd0, key});
        chk("locked_after_commit", {31'd0, lk[0]}, 1);
        start(0);
        chk("err_locked", {31'd0, er[0]}, 1);
        chk("busy_locked", {31'd0, bsy[0]}, 0);
        cyc();
        chk("err_one_cycle", {31'd0, er[0]}, 0);
        chk("ko_locked_hold", {22'd0, ko[0]}, {22'd0, key});

        // Non-locking instance: aborted partial load, then all-ones
        start(1);
        beats(1, 10'b0000000000, 4, 1'b0);
        load_key(1, 10'h3FF, 1'b1, 1'b0);
        chk("ko_restart", {22'd0, ko[1]}, 32'h3FF);
        chk("not_locked", {31'd0, lk[1]}, 0);

        for (int k = 0; k < 3; k++) begin
            key = KL'($urandom);
            load_key(1, key, 1'b1, 1'b1);
            chk("ko_reload", {22'd0, ko[1]}, {22'd0, key});
        end

`ifdef OBF_KEY_PARITY_EN
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        load_key(1, 10'h001, 1'b0, 1'b0);
        chk("ko_bad_parity", {22'd0, ko[1]}, 0);
        load_key(1, 10'h001, 1'b1, 1'b0);
        chk("ko_good_parity", {22'd0, ko[1]}, 32'h001);
`endif

        // Asynchronous reset in the middle of a load
        start(1);
        beats(1, 10'h2C7, 6, 1'b0);
        chk("busy_mid_load", {31'd0, bsy[1]}, 1);
        #2 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("async_key_out", {22'd0, ko[s]}, 0);
            chk("async_busy", {31'd0, bsy[s]}, 0);
            chk("async_ready", {31'd0, rdy[s]}, 0);
            chk("async_locked", {31'd0, lk[s]}, 0);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        load_key(0, 10'h2B5, 1'b1, 1'b0);
        chk("ko_after_reset0", {22'd0, ko[0]}, 32'h2B5);
        load_key(1, 10'h14A, 1'b1, 1'b1);
        chk("ko_after_reset1", {22'd0, ko[1]}, 32'h14A);

        cyc();
        chk("scoreboard_drained", exp_q0.size() + exp_q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
